// File: rtl/wb_regfile_commit_pkg.sv
// Shared definitions for the writeback-commit block: writeback source select
// encoding and default widths used by the interface, top and sub-module.
package wb_regfile_commit_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREGS  = 32;

    typedef logic [1:0] wb_sel_t;

    localparam wb_sel_t WB_SEL_ALU = 2'b00;
    localparam wb_sel_t WB_SEL_MEM = 2'b01;
    localparam wb_sel_t WB_SEL_PC4 = 2'b10;
    localparam wb_sel_t WB_SEL_IMM = 2'b11;

endpackage

// File: rtl/wb_regfile_commit_if.sv
// Bus bundle between the MEM stage / decode stage and the writeback-commit block.
//   master : drives the MEM/WB bundle, stall/flush and decode read addresses;
//            receives read data and the committed write for forwarding.
//   slave  : the writeback-commit block itself.
interface wb_regfile_commit_if
    import wb_regfile_commit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              mw_valid;
    logic              mw_reg_write;
    logic [ADDR_W-1:0] mw_rd;
    wb_sel_t           mw_wb_sel;
    logic [DATA_W-1:0] mw_alu_res;
    logic [DATA_W-1:0] mw_mem_data;
    logic [DATA_W-1:0] mw_pc_plus4;
    logic [DATA_W-1:0] mw_imm;
    logic              wb_stall;
    logic              wb_flush;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output mw_valid, mw_reg_write, mw_rd, mw_wb_sel, mw_alu_res, mw_mem_data,
               mw_pc_plus4, mw_imm, wb_stall, wb_flush, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_we, wb_rd, wb_data
    );

    modport slave (
        input  mw_valid, mw_reg_write, mw_rd, mw_wb_sel, mw_alu_res, mw_mem_data,
               mw_pc_plus4, mw_imm, wb_stall, wb_flush, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_we, wb_rd, wb_data
    );
endinterface

// File: rtl/wb_regfile_commit_src_select.sv
// Writeback source multiplexer.
//   i_sel  : registered source select
//   i_alu  : ALU result, i_mem : load data, i_pc4 : link address, i_imm : immediate
//   o_data : selected writeback value
module wb_src_select
    import wb_regfile_commit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wb_sel_t           i_sel,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [DATA_W-1:0] i_mem,
    input  logic [DATA_W-1:0] i_pc4,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_data
);

    // Pick the writeback value for the registered select.
    always_comb begin
        o_data = i_alu;
        case (i_sel)
            WB_SEL_ALU: o_data = i_alu;
            WB_SEL_MEM: o_data = i_mem;
            WB_SEL_PC4: o_data = i_pc4;
            WB_SEL_IMM: o_data = i_imm;
            default:    o_data = i_alu;
        endcase
    end

endmodule

// File: rtl/wb_regfile_commit.sv
// Writeback-commit stage: MEM/WB stage register, source select, 32-entry
// register file with x0 hardwired to zero, two bypassed decode read ports and
// the committing write exported for EX forwarding.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of wb_regfile_commit_if (bundle in, reads, commit out)
module wb_regfile_commit
    import wb_regfile_commit_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wb_regfile_commit_if.slave   bus
);

    logic              r_valid;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_rd;
    wb_sel_t           r_sel;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mem;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_imm;
    // Set once a held (stalled) instruction has written, so it writes only once.
    logic              r_committed;
    logic [DATA_W-1:0] r_regs [NREGS];

    logic              w_we;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_rs1;
    logic [DATA_W-1:0] w_rs2;

    wb_src_select #(.DATA_W(DATA_W)) u_src_select (
        .i_sel  (r_sel),
        .i_alu  (r_alu),
        .i_mem  (r_mem),
        .i_pc4  (r_pc4),
        .i_imm  (r_imm),
        .o_data (w_data)
    );

    assign w_we = r_valid & r_reg_write & (r_rd != {ADDR_W{1'b0}}) & ~r_committed;

    // Stage register: flush beats stall; a stalled commit marks the entry done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_sel       <= WB_SEL_ALU;
            r_alu       <= '0;
            r_mem       <= '0;
            r_pc4       <= '0;
            r_imm       <= '0;
            r_committed <= 1'b0;
        end else if (bus.wb_flush) begin
            r_valid     <= 1'b0;
            r_committed <= 1'b0;
        end else if (!bus.wb_stall) begin
            r_valid     <= bus.mw_valid;
            r_reg_write <= bus.mw_reg_write;
            r_rd        <= bus.mw_rd;
            r_sel       <= bus.mw_wb_sel;
            r_alu       <= bus.mw_alu_res;
            r_mem       <= bus.mw_mem_data;
            r_pc4       <= bus.mw_pc_plus4;
            r_imm       <= bus.mw_imm;
            r_committed <= 1'b0;
        end else if (w_we) begin
            r_committed <= 1'b1;
        end else begin
            r_committed <= r_committed;
        end
    end

    // Register file commit; x0 is never written because w_we excludes rd==0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[r_rd] <= w_data;
        end else begin
            r_regs[r_rd] <= r_regs[r_rd];
        end
    end

    // Decode read ports with same-cycle bypass of the committing write.
    always_comb begin
        w_rs1 = '0;
        w_rs2 = '0;
        if (bus.rs1_addr == {ADDR_W{1'b0}}) begin
            w_rs1 = '0;
        end else if (w_we && (bus.rs1_addr == r_rd)) begin
            w_rs1 = w_data;
        end else begin
            w_rs1 = r_regs[bus.rs1_addr];
        end
        if (bus.rs2_addr == {ADDR_W{1'b0}}) begin
            w_rs2 = '0;
        end else if (w_we && (bus.rs2_addr == r_rd)) begin
            w_rs2 = w_data;
        end else begin
            w_rs2 = r_regs[bus.rs2_addr];
        end
    end

    assign bus.rs1_data = w_rs1;
    assign bus.rs2_data = w_rs2;
    assign bus.wb_we    = w_we;
    assign bus.wb_rd    = r_rd;
    assign bus.wb_data  = w_data;

endmodule

// File: tb/tb_wb_regfile_commit.sv
// Scoreboard bench for wb_regfile_commit: a reference model predicts which
// accepted bundles commit and the architectural register contents; a monitor
// checks every commit and every read port sample on the falling clock edge.
module tb_wb_regfile_commit;
    import wb_regfile_commit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_regfile_commit_if bus ();

    wb_regfile_commit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: architectural registers plus the one write that
    // was accepted last cycle and is committing now.
    logic [31:0] m_regs [32];
    logic        m_pend;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [36:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] a,
                                         input logic [31:0] m, input logic [31:0] p,
                                         input logic [31:0] i);
        case (s)
            2'd0:    return a;
            2'd1:    return m;
            2'd2:    return p;
            default: return i;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_pend && (m_rd == a)) return m_data;
        return m_regs[a];
    endfunction

    // Model: an accepted write is visible via bypass next cycle, then lands.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_pend <= 1'b0;
            m_rd   <= 5'd0;
            m_data <= 32'd0;
            exp_q.delete();
        end else begin
            if (m_pend) m_regs[m_rd] <= m_data;
            if (!bus.wb_flush && !bus.wb_stall && bus.mw_valid && bus.mw_reg_write &&
                bus.mw_rd != 5'd0) begin
                m_pend <= 1'b1;
                m_rd   <= bus.mw_rd;
                m_data <= pick(bus.mw_wb_sel, bus.mw_alu_res, bus.mw_mem_data,
                               bus.mw_pc_plus4, bus.mw_imm);
                exp_q.push_back({bus.mw_rd, pick(bus.mw_wb_sel, bus.mw_alu_res,
                                 bus.mw_mem_data, bus.mw_pc_plus4, bus.mw_imm)});
            end else begin
                m_pend <= 1'b0;
            end
        end
    end

    // Monitor: every cycle with wb_we must match the next expected commit.
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst_n) begin
            chk("wb_we", {31'd0, bus.wb_we}, {31'd0, m_pend});
            if (bus.wb_we) begin
                if (exp_q.size() == 0) begin
                    chk("commit_unexpected", {31'd0, bus.wb_we}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e[36:32]});
                    chk("wb_data", bus.wb_data, e[31:0]);
                end
            end
            chk("rs1_data", bus.rs1_data, exp_read(bus.rs1_addr));
            chk("rs2_data", bus.rs2_data, exp_read(bus.rs2_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [31:0] imm,
                       input logic st, input logic fl);
        bus.mw_valid     = v;
        bus.mw_reg_write = rw;
        bus.mw_rd        = rd;
        bus.mw_wb_sel    = sel;
        bus.mw_alu_res   = alu;
        bus.mw_mem_data  = mem;
        bus.mw_pc_plus4  = pc4;
        bus.mw_imm       = imm;
        bus.wb_stall     = st;
        bus.wb_flush     = fl;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] sweep [4];
        sweep[0] = 32'h11; sweep[1] = 32'h22; sweep[2] = 32'h33; sweep[3] = 32'h44;
        idle();
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        tick(); tick();
        chk("reset_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("reset_wb_data", bus.wb_data, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a write drops it.
        drv(1'b1, 1'b1, 5'd5, WB_SEL_ALU, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("rst_mid_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        chk("rst_mid_wb_data", bus.wb_data, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        bus.rs1_addr = 5'd5;
        #1;
        chk("rst_reg5", bus.rs1_data, 32'd0);
        chk("rst_release_wb_we", {31'd0, bus.wb_we}, 32'd0);
        tick();

        // Source select sweep into x3.
        for (int s = 0; s < 4; s++) begin
            drv(1'b1, 1'b1, 5'd3, s[1:0], 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 1'b0);
            tick();
            idle();
            tick();
            bus.rs1_addr = 5'd3;
            #1;
            chk("sel_sweep_reg3", bus.rs1_data, sweep[s]);
        end

        // Same-cycle bypass.
        drv(1'b1, 1'b1, 5'd7, WB_SEL_ALU, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        idle();
        bus.rs1_addr = 5'd7;
        #1;
        chk("bypass_rs1", bus.rs1_data, 32'h1234_5678);
        tick();

        // x0 write suppressed.
        drv(1'b1, 1'b1, 5'd0, WB_SEL_IMM, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        idle();
        bus.rs2_addr = 5'd0;
        #1;
        chk("x0_wb_we", {31'd0, bus.wb_we}, 32'd0);
        chk("x0_rs2", bus.rs2_data, 32'd0);
        tick();

        // Stall for three cycles: single write, wb_we only in the first.
        drv(1'b1, 1'b1, 5'd9, WB_SEL_ALU, 32'hA5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 1'b1, 5'd10, WB_SEL_ALU, 32'h5A, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1 chk("stall_c1_wb_we", {31'd0, bus.wb_we}, 32'd1);
        tick();
        #1 chk("stall_c2_wb_we", {31'd0, bus.wb_we}, 32'd0);
        tick();
        #1 chk("stall_c3_wb_we", {31'd0, bus.wb_we}, 32'd0);
        idle();
        tick();
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd10;
        #1;
        chk("stall_reg9", bus.rs1_data, 32'hA5);
        chk("stall_reg10", bus.rs2_data, 32'd0);
        tick();

        // Flush kills the incoming bundle.
        drv(1'b1, 1'b1, 5'd4, WB_SEL_MEM, 32'd0, 32'h4444, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 1'b1, 5'd4, WB_SEL_ALU, 32'hBAD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        tick();
        idle();
        #1 chk("flush_wb_we", {31'd0, bus.wb_we}, 32'd0);
        tick();
        bus.rs1_addr = 5'd4;
        #1 chk("flush_reg4", bus.rs1_data, 32'h4444);
        tick();

        // Randomized traffic with stalls and flushes.
        for (int c = 0; c < 600; c++) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            bus.rs1_addr = 5'($urandom_range(0, 31));
            bus.rs2_addr = ($urandom_range(0, 3) == 0) ? bus.rs1_addr
                                                        : 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        tick(); tick(); tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
